// File: rtl/dcnn_io_pkg.sv
// dcnn_io_pkg
// Shared definitions for the compressed-stream handler drivers. It holds the
// fetcher state encoding, the code-byte field positions and the default
// handler timeout.
// Ports: none (package).
package dcnn_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_ADV,
    ST_FIN
  } fetch_state_e;

  // A code byte is {value bit[7], run[6:0]}.
  localparam int CODE_RUN_MSB    = 6;
  localparam int CODE_VAL_BIT    = 7;
  localparam int DEFAULT_TIMEOUT = 255;

  // Returns the run-length field zero-extended to a full byte.
  function automatic logic [7:0] code_run(input logic [7:0] code);
    code_run = {{(7 - CODE_RUN_MSB){1'b0}}, code[CODE_RUN_MSB:0]};
  endfunction

  // Returns the value bit of a code byte.
  function automatic logic code_val(input logic [7:0] code);
    code_val = code[CODE_VAL_BIT];
  endfunction

endpackage

// File: rtl/pair_timeout_counter.sv
// pair_timeout_counter
// Watchdog for one handler transaction. Clearing reloads the count. Each
// enabled cycle counts down one step. o_expired rises in the enabled cycle
// that completes TIMEOUT waiting cycles.
// Ports:
//   i_clk      clock, posedge
//   i_rst      synchronous active-high reset
//   i_clr      reload the count (start of a transaction)
//   i_en       count this cycle (waiting for the handler)
//   o_expired  TIMEOUT enabled cycles have elapsed since the last clear
module pair_timeout_counter
  import dcnn_io_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // A zero timeout would never expire, so one cycle is the floor.
  localparam int TMO   = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TMO - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= LOAD;
    end else if (i_clr) begin
      r_count <= LOAD;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // The count reaches zero in the TIMEOUT-th enabled cycle.
  assign o_expired = i_en && (r_count == '0);

endmodule

// File: rtl/compressed_pair_fetcher.sv
// compressed_pair_fetcher
// Walks a run-length stream of 2-byte code pairs in RAM. For each pair it
// reads both bytes over the DMA port and hands them to decompress_handler
// together with the destination bit pointer. It then waits for done and
// adopts the pointer that the handler returns.
// Ports:
//   clk, RST                      clock; synchronous active-high reset
//   start, srcBase, pairCount,
//   dstByteStart, dstBitStart     job launch and parameters
//   ramAddress, read_signal,
//   ramDataOut, doneRead          DMA read port
//   in1, in2, byteIndx, bitIndx,
//   work, working                 handler request
//   done, newByteIndx, newBitIndx handler response
//   busy, finished, timeoutErr,
//   pairsDone                     job status
//
// state  | meaning
// IDLE   | waiting for start
// RD1    | reading the first code byte of the pair
// RD2    | reading the second code byte of the pair
// CHECK  | skipping the pair if both run fields are zero
// ISSUE  | handler enabled, watchdog reloaded
// WAIT   | waiting for handler done or watchdog expiry
// ADV    | counting the pair, then next pair or finish
// FIN    | one-cycle wrap-up; finished pulses on the following cycle
module compressed_pair_fetcher
  import dcnn_io_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcBase,
  input  logic [15:0]       pairCount,
  input  logic [31:0]       dstByteStart,
  input  logic [2:0]        dstBitStart,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              read_signal,
  input  logic [7:0]        ramDataOut,
  input  logic              doneRead,
  output logic [7:0]        in1,
  output logic [7:0]        in2,
  output logic [31:0]       byteIndx,
  output logic [2:0]        bitIndx,
  output logic              work,
  output logic              working,
  input  logic              done,
  input  logic [31:0]       newByteIndx,
  input  logic [2:0]        newBitIndx,
  output logic              busy,
  output logic              finished,
  output logic              timeoutErr,
  output logic [15:0]       pairsDone
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_src_base;
  logic [15:0]       r_pair_count;
  logic [15:0]       r_pair_idx;
  logic [ADDR_W-1:0] r_ram_address;
  logic              r_read;
  logic [7:0]        r_in1;
  logic [7:0]        r_in2;
  logic [31:0]       r_byte_indx;
  logic [2:0]        r_bit_indx;
  logic              r_work;
  logic              r_busy;
  logic              r_finished;
  logic              r_timeout_err;
  logic [15:0]       r_pairs_done;

  logic [15:0]       w_next_idx;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_run_sum;
  logic              w_expired;

  assign w_next_idx  = r_pair_idx + 16'd1;
  // Each pair is two bytes. The sum wraps at the top of RAM.
  assign w_next_addr = r_src_base + ADDR_W'({w_next_idx, 1'b0});
  assign w_run_sum   = code_run(r_in1) + code_run(r_in2);

  pair_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (clk),
    .i_rst     (RST),
    .i_clr     (r_state == ST_ISSUE),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_src_base    <= '0;
      r_pair_count  <= '0;
      r_pair_idx    <= '0;
      r_ram_address <= '0;
      r_read        <= 1'b0;
      r_in1         <= '0;
      r_in2         <= '0;
      r_byte_indx   <= '0;
      r_bit_indx    <= '0;
      r_work        <= 1'b0;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pairs_done  <= '0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src_base    <= srcBase;
            r_pair_count  <= pairCount;
            r_pair_idx    <= '0;
            r_pairs_done  <= '0;
            r_timeout_err <= 1'b0;
            r_byte_indx   <= dstByteStart;
            r_bit_indx    <= dstBitStart;
            r_busy        <= 1'b1;
            if (pairCount == 16'd0) begin
              r_state <= ST_FIN;
            end else begin
              r_ram_address <= srcBase;
              r_read        <= 1'b1;
              r_state       <= ST_RD1;
            end
          end
        end
        ST_RD1: begin
          // The request stays up into RD2; only the address moves on.
          if (doneRead) begin
            r_in1         <= ramDataOut;
            r_ram_address <= r_ram_address + ADDR_W'(1);
            r_state       <= ST_RD2;
          end
        end
        ST_RD2: begin
          if (doneRead) begin
            r_in2   <= ramDataOut;
            r_read  <= 1'b0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_run_sum == 8'd0) begin
            r_state <= ST_ADV;
          end else begin
            r_work  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over an expiry in the same cycle.
          if (done) begin
            r_byte_indx <= newByteIndx;
            r_bit_indx  <= newBitIndx;
            r_work      <= 1'b0;
            r_state     <= ST_ADV;
          end else if (w_expired) begin
            r_timeout_err <= 1'b1;
            r_work        <= 1'b0;
            r_state       <= ST_FIN;
          end
        end
        ST_ADV: begin
          r_pair_idx   <= w_next_idx;
          r_pairs_done <= r_pairs_done + 16'd1;
          if (w_next_idx == r_pair_count) begin
            r_state <= ST_FIN;
          end else begin
            r_ram_address <= w_next_addr;
            r_read        <= 1'b1;
            r_state       <= ST_RD1;
          end
        end
        ST_FIN: begin
          r_finished <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ramAddress  = r_ram_address;
  assign read_signal = r_read;
  assign in1         = r_in1;
  assign in2         = r_in2;
  assign byteIndx    = r_byte_indx;
  assign bitIndx     = r_bit_indx;
  assign work        = r_work;
  assign working     = r_work;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign timeoutErr  = r_timeout_err;
  assign pairsDone   = r_pairs_done;

endmodule

// File: tb/tb_compressed_pair_fetcher.sv
module tb_compressed_pair_fetcher;

  localparam int ADDR_W = 16;
  localparam int TMO    = 10;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] srcBase;
  logic [15:0] pairCount;
  logic [31:0] dstByteStart;
  logic [2:0]  dstBitStart;
  logic [15:0] ramAddress;
  logic        read_signal;
  logic [7:0]  ramDataOut;
  logic        doneRead;
  logic [7:0]  in1, in2;
  logic [31:0] byteIndx;
  logic [2:0]  bitIndx;
  logic        work, working;
  logic        done;
  logic [31:0] newByteIndx;
  logic [2:0]  newBitIndx;
  logic        busy, finished, timeoutErr;
  logic [15:0] pairsDone;

  always #5 clk = ~clk;

  compressed_pair_fetcher #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .RST(RST), .start(start), .srcBase(srcBase), .pairCount(pairCount),
    .dstByteStart(dstByteStart), .dstBitStart(dstBitStart),
    .ramAddress(ramAddress), .read_signal(read_signal), .ramDataOut(ramDataOut),
    .doneRead(doneRead), .in1(in1), .in2(in2), .byteIndx(byteIndx), .bitIndx(bitIndx),
    .work(work), .working(working), .done(done), .newByteIndx(newByteIndx),
    .newBitIndx(newBitIndx), .busy(busy), .finished(finished), .timeoutErr(timeoutErr),
    .pairsDone(pairsDone)
  );

  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [31:0] byt; logic [2:0] pbit;} issue_t;
  typedef struct packed {logic [15:0] pd; logic [31:0] byt; logic [2:0] pbit; logic terr;} fin_t;
  typedef struct packed {logic [31:0] byt; logic [2:0] pbit;} ret_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr[$];
  issue_t      exp_iss[$];
  fin_t        exp_fin[$];
  ret_t        ret_q[$];

  int errors = 0;
  int checks = 0;
  int fin_cnt = 0;
  int reads_seen = 0;
  bit handler_en = 1'b1;
  bit spurious_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // DMA responder: random 0..3 cycle latency per byte.
  initial begin
    automatic bit pend = 1'b0;
    automatic int dly = 0;
    doneRead = 1'b0;
    ramDataOut = 8'h00;
    forever begin
      @(negedge clk);
      if (!read_signal) begin
        pend = 1'b0;
        doneRead = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1;
          dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin
          doneRead = 1'b1;
          ramDataOut = mem[ramAddress];
          pend = 1'b0;
        end else begin
          dly--;
          doneRead = 1'b0;
        end
      end
    end
  end

  // Handler model. It answers 1..4 cycles after work rises and sometimes
  // pulses done while idle, which the fetcher must ignore.
  initial begin
    automatic bit active = 1'b0;
    automatic int hcnt = 0;
    automatic ret_t r;
    done = 1'b0;
    newByteIndx = '0;
    newBitIndx = '0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (RST) begin
        active = 1'b0;
      end else if (work && !active && handler_en) begin
        active = 1'b1;
        hcnt = $urandom_range(1, 4);
      end else if (active) begin
        hcnt--;
        if (hcnt == 0) begin
          if (ret_q.size() > 0) r = ret_q.pop_front();
          else r = {$urandom(), 3'($urandom_range(0, 7))};
          done = 1'b1;
          newByteIndx = r.byt;
          newBitIndx = r.pbit;
          active = 1'b0;
        end
      end else if (!work && spurious_en && ($urandom_range(0, 7) == 0)) begin
        done = 1'b1;
        newByteIndx = $urandom();
        newBitIndx = 3'($urandom_range(0, 7));
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    automatic logic work_q = 1'b0;
    automatic issue_t ei;
    automatic fin_t ef;
    forever begin
      @(negedge clk);
      #1;
      if (RST) begin
        work_q = 1'b0;
      end else begin
        if (read_signal && doneRead) begin
          reads_seen++;
          if (exp_addr.size() == 0) chk("read_unexpected", doneRead, 0);
          else chk("read_addr", ramAddress, exp_addr.pop_front());
        end
        if (work && !work_q) begin
          if (exp_iss.size() == 0) chk("work_unexpected", work, 0);
          else begin
            ei = exp_iss.pop_front();
            chk("issue_in1_in2_ptr", {in1, in2, byteIndx, bitIndx}, ei);
            chk("working_eq_work", working, 1);
          end
        end
        if (finished) begin
          fin_cnt++;
          if (exp_fin.size() == 0) chk("finished_unexpected", finished, 0);
          else begin
            ef = exp_fin.pop_front();
            chk("finish_pd_ptr_terr", {pairsDone, byteIndx, bitIndx, timeoutErr}, ef);
          end
        end
        work_q = work;
      end
    end
  end

  // Reference model: walks the pairs with plain arithmetic and queues the
  // expected reads, handler requests, handler replies and the job result.
  task automatic model(input logic [15:0] src, input int cnt, input logic [31:0] db,
                       input logic [2:0] dbit, input bit inc_ret);
    automatic logic [15:0] a;
    automatic logic [31:0] pb = db;
    automatic logic [2:0]  pbt = dbit;
    automatic ret_t r;
    for (int i = 0; i < cnt; i++) begin
      a = src + 16'(2 * i);
      exp_addr.push_back(a);
      exp_addr.push_back(a + 16'd1);
      if ((mem[a] % 128) == 0 && (mem[a + 16'd1] % 128) == 0) continue;
      exp_iss.push_back({mem[a], mem[a + 16'd1], pb, pbt});
      if (inc_ret) r = {pb + 32'd1, pbt};
      else r = {$urandom(), 3'($urandom_range(0, 7))};
      ret_q.push_back(r);
      pb = r.byt;
      pbt = r.pbit;
    end
    exp_fin.push_back({16'(cnt), pb, pbt, 1'b0});
  endtask

  task automatic start_job(input logic [15:0] src, input logic [15:0] cnt,
                           input logic [31:0] db, input logic [2:0] dbit);
    @(negedge clk);
    srcBase = src;
    pairCount = cnt;
    dstByteStart = db;
    dstBitStart = dbit;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fin(input int prev, input string name);
    for (int k = 0; k < 3000 && fin_cnt <= prev; k++) @(negedge clk);
    #2;
    chk(name, fin_cnt, prev + 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ramAddress"}, ramAddress, 0);
    chk({tag, "_read_signal"}, read_signal, 0);
    chk({tag, "_in1_in2"}, {in1, in2}, 0);
    chk({tag, "_ptr"}, {byteIndx, bitIndx}, 0);
    chk({tag, "_work_working"}, {work, working}, 0);
    chk({tag, "_busy_fin_terr"}, {busy, finished, timeoutErr}, 0);
    chk({tag, "_pairsDone"}, pairsDone, 0);
  endtask

  task automatic fill_pairs(input logic [15:0] src, input int cnt);
    automatic logic [15:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = src + 16'(2 * i);
      if ($urandom_range(0, 3) == 0) begin
        mem[a] = 8'($urandom_range(0, 1) << 7);
        mem[a + 16'd1] = 8'($urandom_range(0, 1) << 7);
      end else begin
        mem[a] = 8'($urandom());
        mem[a + 16'd1] = 8'($urandom_range(1, 127)) | 8'($urandom_range(0, 1) << 7);
      end
    end
  endtask

  initial begin
    automatic int prev;
    automatic int rs;
    automatic bit found;
    automatic logic [15:0] src;
    automatic int cnt;
    RST = 1'b1;
    start = 1'b0;
    srcBase = '0;
    pairCount = '0;
    dstByteStart = '0;
    dstBitStart = '0;
    repeat (3) @(negedge clk);
    #2;
    check_zero("reset");
    RST = 1'b0;

    // Basic pair.
    mem[16'h0100] = 8'h83;
    mem[16'h0101] = 8'h05;
    model(16'h0100, 1, 32'h2000, 3'd7, 1'b1);
    prev = fin_cnt;
    start_job(16'h0100, 16'd1, 32'h2000, 3'd7);
    wait_fin(prev, "basic_finished");
    chk("basic_ptr", {byteIndx, bitIndx}, {32'h2001, 3'd7});
    chk("basic_pairsDone", pairsDone, 1);
    chk("basic_terr", timeoutErr, 0);

    // Three pairs, random read latency, random handler pointers.
    for (int i = 0; i < 6; i++) mem[16'h0100 + 16'(i)] = 8'($urandom_range(1, 255)) | 8'h01;
    model(16'h0100, 3, 32'h0000_1234, 3'd2, 1'b0);
    prev = fin_cnt;
    start_job(16'h0100, 16'd3, 32'h0000_1234, 3'd2);
    wait_fin(prev, "three_finished");

    // Empty pair.
    mem[16'h0200] = 8'h00;
    mem[16'h0201] = 8'h80;
    model(16'h0200, 1, 32'h55, 3'd3, 1'b0);
    prev = fin_cnt;
    start_job(16'h0200, 16'd1, 32'h55, 3'd3);
    wait_fin(prev, "empty_finished");
    chk("empty_ptr", {byteIndx, bitIndx}, {32'h55, 3'd3});
    chk("empty_pairsDone", pairsDone, 1);

    // Zero-count job.
    exp_fin.push_back({16'd0, 32'hABCD, 3'd5, 1'b0});
    rs = reads_seen;
    prev = fin_cnt;
    start_job(16'h0300, 16'd0, 32'hABCD, 3'd5);
    #2;
    chk("zero_busy_c1", busy, 1);
    chk("zero_fin_c1", finished, 0);
    @(negedge clk);
    #2;
    chk("zero_fin_c2", finished, 1);
    chk("zero_busy_c2", busy, 0);
    wait_fin(prev, "zero_finished");
    chk("zero_no_reads", reads_seen, rs);

    // Handler never answers; a start during WAIT is ignored.
    handler_en = 1'b0;
    mem[16'h0400] = 8'h12;
    mem[16'h0401] = 8'h34;
    mem[16'h0402] = 8'h56;
    mem[16'h0403] = 8'h78;
    exp_addr.push_back(16'h0400);
    exp_addr.push_back(16'h0401);
    exp_iss.push_back({8'h12, 8'h34, 32'h777, 3'd1});
    exp_fin.push_back({16'd0, 32'h777, 3'd1, 1'b1});
    prev = fin_cnt;
    start_job(16'h0400, 16'd2, 32'h777, 3'd1);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (work) begin found = 1'b1; break; end
      @(negedge clk);
      #2;
    end
    chk("tmo_work_seen", found, 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) begin
        srcBase = 16'h0900;
        pairCount = 16'd5;
        start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      #2;
      if (k == 10) begin
        chk("tmo_err_before", timeoutErr, 0);
        chk("tmo_work_before", work, 1);
      end
      if (k == 11) begin
        chk("tmo_err_after", timeoutErr, 1);
        chk("tmo_work_after", work, 0);
      end
    end
    wait_fin(prev, "tmo_finished");
    repeat (5) @(negedge clk);
    #2;
    chk("tmo_start_ignored_busy", busy, 0);

    // Reset in WAIT.
    mem[16'h0500] = 8'h11;
    mem[16'h0501] = 8'h22;
    model(16'h0500, 3, 32'h4444, 3'd4, 1'b0);
    start_job(16'h0500, 16'd3, 32'h4444, 3'd4);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (work) begin found = 1'b1; break; end
      @(negedge clk);
      #2;
    end
    chk("rstw_work_seen", found, 1);
    @(negedge clk);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    exp_addr.delete();
    exp_iss.delete();
    exp_fin.delete();
    ret_q.delete();
    #2;
    check_zero("midrst");
    handler_en = 1'b1;
    repeat (6) @(negedge clk);

    // Random jobs, one of them wrapping past the top of RAM.
    for (int j = 0; j < 8; j++) begin
      src = (j == 3) ? 16'hFFFC : 16'($urandom());
      cnt = $urandom_range(1, 6);
      fill_pairs(src, cnt);
      model(src, cnt, $urandom(), 3'($urandom_range(0, 7)), 1'b0);
      prev = fin_cnt;
      start_job(src, 16'(cnt), exp_iss.size() > 0 ? exp_iss[0].byt : exp_fin[0].byt,
                exp_iss.size() > 0 ? exp_iss[0].pbit : exp_fin[0].pbit);
      wait_fin(prev, "rand_finished");
      chk("rand_pairsDone", pairsDone, cnt);
    end

    chk("leftover_reads", exp_addr.size(), 0);
    chk("leftover_issues", exp_iss.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compressed_pair_fetcher.md
# compressed_pair_fetcher

Upstream feeder for `decompress_handler`. It walks a compressed run-length stream stored in RAM, where each entry is a pair of code bytes {value bit[7], run[6:0]}. For each pair it reads both bytes through a dedicated DMA read port, presents them as `in1`/`in2` with the current destination bit pointer, and waits for the handler's `done`. It then adopts the handler's returned pointer and moves to the next pair, until `pairCount` pairs are consumed or a timeout fires.

## Interface
Parameters:
- `ADDR_W`, 16: RAM address width.
- `TIMEOUT`, 255: maximum cycles to wait for handler `done` per pair.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a job; ignored unless idle.
- `srcBase` in ADDR_W: address of the first code byte.
- `pairCount` in 16: number of pairs to process.
- `dstByteStart` in 32: initial destination byte index.
- `dstBitStart` in 3: initial destination bit index (7 = MSB of a fresh byte).
- `ramAddress` out ADDR_W: DMA read address.
- `read_signal` out 1: DMA read request.
- `ramDataOut` in 8: DMA read data.
- `doneRead` in 1: DMA read complete; data valid this cycle.
- `in1`, `in2` out 8: code bytes to the handler.
- `byteIndx` out 32, `bitIndx` out 3: current destination pointer to the handler.
- `work` out 1, `working` out 1: handler enables.
- `done` in 1: handler finished the current pair.
- `newByteIndx` in 32, `newBitIndx` in 3: pointer returned by the handler.
- `busy` out 1: job active.
- `finished` out 1: one-cycle pulse when the job completes or aborts.
- `timeoutErr` out 1: sticky abort flag; cleared by `start` or `RST`.
- `pairsDone` out 16: pairs completed in the current job.

## Operation
- States: IDLE, RD1, RD2, CHECK, ISSUE, WAIT, ADV, FIN.
- IDLE, on `start`:
  - latch the job inputs;
  - set `byteIndx`/`bitIndx` to `dstByteStart`/`dstBitStart`;
  - clear `pairsDone`, `timeoutErr` and `pairIdx`;
  - go to RD1, or to FIN if `pairCount` is 0.
- RD1:
  - `ramAddress` = srcBase + 2·pairIdx, `read_signal` = 1;
  - hold both until `doneRead`;
  - on `doneRead`, capture `ramDataOut` into `in1` and go to RD2.
- RD2: same as RD1 with address + 1, capturing into `in2`; then go to CHECK.
- CHECK:
  - if in1[6:0] + in2[6:0] = 0 (8-bit sum), the pair is empty: go to ADV and leave the pointer unchanged;
  - otherwise go to ISSUE.
- ISSUE: assert `work` = 1 and `working` = 1; clear the timeout counter; go to WAIT.
- WAIT:
  - hold `work`, `working`, `in1`, `in2`, `byteIndx` and `bitIndx` stable;
  - on `done`, register `newByteIndx`/`newBitIndx` into `byteIndx`/`bitIndx`, drop `work`/`working`, and go to ADV;
  - if the counter reaches TIMEOUT first, set `timeoutErr`, drop the enables, and go to FIN.
- ADV:
  - increment `pairIdx` and `pairsDone`;
  - if `pairIdx` + 1 = `pairCount`, go to FIN; else go to RD1.
- FIN: pulse `finished` for one cycle and go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top of RAM is legal and silent.
- `start` while `busy` is ignored. A `done` pulse outside WAIT is ignored.
- `done` and the timeout expiring in the same cycle: `done` wins.

## Timing
- Reset values:
  - state = IDLE;
  - `ramAddress`, `read_signal`, `in1`, `in2`, `byteIndx`, `bitIndx` = 0;
  - `work`, `working`, `busy`, `finished`, `timeoutErr` = 0;
  - `pairsDone` = 0.
- `RST` mid-job aborts at the next edge: outputs return to reset values and no `finished` pulse is issued.
- `busy` = 1 from the cycle after `start` through FIN inclusive.
- Read handshake: the request is held high through the `doneRead` cycle and dropped the following cycle. The minimum read costs 1 cycle when `doneRead` is immediate.
- Best-case per-pair latency with an immediate `doneRead` and `done` one cycle after ISSUE: RD1, RD2, CHECK, ISSUE, WAIT, ADV = 6 cycles.
- The pointer update is visible on `byteIndx`/`bitIndx` in the cycle after `done` is sampled.
- `work` rises no earlier than the cycle after `in1`/`in2` are stable.

## Structure
- Shared package `dcnn_io_pkg`:
  - state enum;
  - CODE_RUN_MSB = 6 and CODE_VAL_BIT = 7 constants;
  - default TIMEOUT.
- Sub-module `pair_timeout_counter`: clear, enable, and an expired flag at TIMEOUT. It is reusable by other handler drivers.
- Everything else stays inline in one FSM.

## Test plan
- Basic pair:
  - Stimulus: srcBase = 0x0100, pairCount = 1, mem[0x100] = 0x83, mem[0x101] = 0x05, dst = 0x2000/7; handler model returns 0x2001/7.
  - Required: `in1` = 0x83, `in2` = 0x05, `byteIndx` becomes 0x2001, `pairsDone` = 1, one `finished` pulse, `timeoutErr` = 0.
- Three pairs with variable `doneRead` delay of 0–3 cycles:
  - Required: addresses 0x100–0x105 issued in order, and each pair's pointer equals the previous handler return.
- Empty pair mem = {0x00, 0x80}:
  - Required: `work` never asserted, pointer unchanged, `pairsDone` increments.
- Zero-count job, `pairCount` = 0:
  - Required: no `read_signal`, `finished` 2 cycles after `start`.
- Handler never asserts `done`, TIMEOUT = 10:
  - Required: `timeoutErr` = 1 after 10 WAIT cycles, `finished` pulses, `pairsDone` = 0.
  - A `start` during WAIT is ignored.
- Reset mid-WAIT:
  - Required: all outputs return to reset values next cycle, no `finished`.
  - A following `start` runs normally.
